// File: rtl/tx_serial_7o1_pkg.sv
// Shared constants for the 7O1 serial transmitter: state codes, frame geometry
// and the parity helper.
package tx_serial_7o1_pkg;

  localparam int CLOCKS_PER_BIT_DEF = 434;
  localparam int FRAME_BITS         = 10;
  localparam int SHIFT_W            = FRAME_BITS + 1;

  typedef logic [2:0] state_t;

  localparam logic [2:0] ST_INICIAL     = 3'd0;
  localparam logic [2:0] ST_PREPARACAO  = 3'd1;
  localparam logic [2:0] ST_TRANSMISSAO = 3'd2;
  localparam logic [2:0] ST_ESPERA      = 3'd3;
  localparam logic [2:0] ST_FINAL       = 3'd4;

  // Odd parity: data plus parity bit always hold an odd number of ones.
  function automatic logic odd_parity(input logic [6:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/tx_serial_7o1_baud_cnt.sv
// Modulo-M bit-time counter with synchronous clear and count enable; end_o
// flags the last count of a bit period.
module tx_serial_7o1_baud_cnt #(
  parameter int M = 434,
  localparam int W = (M > 1) ? $clog2(M) : 1
) (
  input  logic clock,
  input  logic reset,
  input  logic clear_i,
  input  logic enable_i,
  output logic end_o
);

  localparam logic [W-1:0] LAST = W'(M - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign end_o = (count_q == LAST);

endmodule

// File: rtl/tx_serial_7o1.sv
// UART-style 7O1 transmitter: start bit, 7 data bits LSB first, odd parity,
// stop bit, launched by a rising edge on partida.
module tx_serial_7o1
  import tx_serial_7o1_pkg::*;
#(
  parameter int CLOCKS_PER_BIT = CLOCKS_PER_BIT_DEF,
  parameter int STATE_W        = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               partida,
  input  logic [6:0]         dados_ascii,
  output logic               saida_serial,
  output logic               pronto,
  output logic               db_partida,
  output logic               db_saida_serial,
  output logic [STATE_W-1:0] db_estado
);

  state_t               state_q, state_d;
  logic [SHIFT_W-1:0]   shift_q, shift_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic                 partida_q;
  logic                 start;
  logic                 baud_clear;
  logic                 baud_enable;
  logic                 baud_end;

  assign start = partida & ~partida_q;

  tx_serial_7o1_baud_cnt #(
    .M(CLOCKS_PER_BIT)
  ) u_baud_cnt (
    .clock    (clock),
    .reset    (reset),
    .clear_i  (baud_clear),
    .enable_i (baud_enable),
    .end_o    (baud_end)
  );

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    baud_clear  = 1'b0;
    baud_enable = 1'b0;
    case (state_q)
      ST_INICIAL: begin
        if (start) state_d = ST_PREPARACAO;
      end
      ST_PREPARACAO: begin
        // Trailing 1 keeps the line idle until the first shift exposes the start bit.
        shift_d    = {1'b1, odd_parity(dados_ascii), dados_ascii, 1'b0, 1'b1};
        bit_cnt_d  = '0;
        baud_clear = 1'b1;
        state_d    = ST_TRANSMISSAO;
      end
      ST_TRANSMISSAO: begin
        shift_d = {1'b1, shift_q[SHIFT_W-1:1]};
        state_d = ST_ESPERA;
      end
      ST_ESPERA: begin
        baud_enable = 1'b1;
        if (baud_end) begin
          if (bit_cnt_q == 4'(FRAME_BITS - 1)) begin
            state_d = ST_FINAL;
          end else begin
            shift_d   = {1'b1, shift_q[SHIFT_W-1:1]};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      ST_FINAL: begin
        state_d = ST_INICIAL;
      end
      default: begin
        state_d = ST_INICIAL;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= ST_INICIAL;
      shift_q   <= '1;
      bit_cnt_q <= '0;
      partida_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      partida_q <= partida;
    end
  end

  assign saida_serial    = shift_q[0];
  assign pronto          = (state_q == ST_FINAL);
  assign db_partida      = partida;
  assign db_saida_serial = saida_serial;
  assign db_estado       = STATE_W'(state_q);

endmodule

// File: tb/tb_tx_serial_7o1.sv
// Randomised and directed bench for tx_serial_7o1 with a cycle-timeline model
// of the frame and a per-cycle output compare.
module tb_tx_serial_7o1;

  localparam int CPB = 434;

  logic       clock = 1'b0;
  logic       reset;
  logic       partida;
  logic [6:0] dados_ascii;
  logic       saida_serial;
  logic       pronto;
  logic       db_partida;
  logic       db_saida_serial;
  logic [3:0] db_estado;

  int errors = 0;
  int checks = 0;
  int pronto_cnt = 0;

  tx_serial_7o1 #(
    .CLOCKS_PER_BIT(CPB),
    .STATE_W(4)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .partida         (partida),
    .dados_ascii     (dados_ascii),
    .saida_serial    (saida_serial),
    .pronto          (pronto),
    .db_partida      (db_partida),
    .db_saida_serial (db_saida_serial),
    .db_estado       (db_estado)
  );

  always #10 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Bit i of the result is the i-th bit placed on the line.
  function automatic logic [9:0] frame_bits(input logic [6:0] d);
    return {1'b1, ~^d, d, 1'b0};
  endfunction

  // Timeline model: a frame accepted at edge k owns edges k .. k+3+10*CPB.
  longint     cyc = 0;
  longint     k_edge = 0;
  bit         m_active = 0;
  bit         m_prev = 0;
  bit         m_valid = 0;
  logic [6:0] m_data = '0;
  logic       exp_line = 1'b1;
  logic       exp_pronto = 1'b0;
  logic [3:0] exp_state = 4'd0;

  always @(posedge clock) begin
    longint     rel;
    logic [9:0] fb;
    cyc++;
    if (reset) begin
      m_active = 0;
      m_prev   = 0;
      m_valid  = 1;
    end else begin
      if (!m_active && partida && !m_prev) begin
        m_active = 1;
        k_edge   = cyc;
      end
      m_prev = partida;
      if (m_active && (cyc - k_edge) == 1) m_data = dados_ascii;
      if (m_active && (cyc - k_edge) >= 3 + 10 * CPB) m_active = 0;
    end
    exp_line   = 1'b1;
    exp_pronto = 1'b0;
    exp_state  = 4'd0;
    if (m_active) begin
      rel = cyc - k_edge;
      fb  = frame_bits(m_data);
      if (rel == 0) exp_state = 4'd1;
      else if (rel == 1) exp_state = 4'd2;
      else if (rel < 2 + 10 * CPB) begin
        exp_state = 4'd3;
        exp_line  = fb[int'((rel - 2) / CPB)];
      end else begin
        exp_state  = 4'd4;
        exp_pronto = 1'b1;
      end
    end
  end

  always @(negedge clock) begin
    if (m_valid) begin
      check("cycle {line,pronto,estado,db_partida,db_line}",
            32'({saida_serial, pronto, db_estado, db_partida, db_saida_serial}),
            32'({exp_line, exp_pronto, exp_state, partida, exp_line}));
    end
    if (pronto === 1'b1) pronto_cnt++;
  end

  task automatic capture(output logic [9:0] cap, output int lat);
    lat = 0;
    cap = '1;
    while (saida_serial !== 1'b0 && lat < 20) begin
      @(negedge clock);
      lat++;
    end
    if (lat >= 20) begin
      check("start bit timeout", 32'(lat), 32'd3);
      return;
    end
    repeat (CPB / 2) @(negedge clock);
    cap[0] = saida_serial;
    for (int i = 1; i < 10; i++) begin
      repeat (CPB) @(negedge clock);
      cap[i] = saida_serial;
    end
  endtask

  task automatic send(input logic [6:0] d, input int hold, input bit disturb,
                      input logic [9:0] exp_bits);
    logic [9:0] cap;
    int         lat;
    int         p0;
    @(negedge clock);
    dados_ascii = d;
    partida     = 1'b1;
    p0          = pronto_cnt;
    fork
      begin
        repeat (hold) @(negedge clock);
        partida = 1'b0;
      end
      begin
        capture(cap, lat);
      end
      begin
        if (disturb) begin
          repeat (3 * CPB) @(negedge clock);
          dados_ascii = ~d;
          partida     = 1'b1;
          @(negedge clock);
          partida = 1'b0;
        end
      end
    join
    repeat (CPB) @(negedge clock);
    repeat (5) @(negedge clock);
    check("start latency", 32'(lat), 32'd3);
    check("frame bits", 32'(cap), 32'(exp_bits));
    check("pronto pulses", 32'(pronto_cnt - p0), 32'd1);
    $display("frame data=%02h hold=%0d disturb=%0d line=%b expected=%b", d, hold, disturb, cap, exp_bits);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int         p0;
    logic [6:0] rd;
    reset       = 1'b1;
    partida     = 1'b0;
    dados_ascii = 7'h00;

    check("model 0x35", 32'(frame_bits(7'h35)), 32'h36A);
    check("model 0x7F", 32'(frame_bits(7'h7F)), 32'h2FE);

    repeat (20) @(negedge clock);
    check("reset line", 32'(saida_serial), 32'd1);
    check("reset pronto", 32'(pronto), 32'd0);
    check("reset estado", 32'(db_estado), 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("idle estado", 32'(db_estado), 32'd0);

    send(7'h35, 25, 0, 10'b1101101010);
    send(7'h55, 1, 0, 10'b1110101010);
    send(7'h7E, 1, 0, 10'b1111111100);
    send(7'h7F, 1, 0, 10'b1011111110);
    send(7'h41, 3, 1, 10'b1110000010);

    // Abort during the data bits.
    @(negedge clock);
    dados_ascii = 7'h33;
    partida     = 1'b1;
    p0          = pronto_cnt;
    @(negedge clock);
    partida = 1'b0;
    repeat (3 * CPB) @(negedge clock);
    check("mid-frame estado", 32'(db_estado), 32'd3);
    reset = 1'b1;
    @(negedge clock);
    check("abort line", 32'(saida_serial), 32'd1);
    check("abort estado", 32'(db_estado), 32'd0);
    reset = 1'b0;
    repeat (12 * CPB) @(negedge clock);
    check("abort no pronto", 32'(pronto_cnt - p0), 32'd0);
    $display("abort data=33 pronto_delta=%0d", pronto_cnt - p0);

    send(7'h2A, 2, 0, frame_bits(7'h2A));

    for (int i = 0; i < 3; i++) begin
      rd = 7'($urandom_range(0, 127));
      send(rd, int'($urandom_range(1, 30)), 0, frame_bits(rd));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
